// File: rtl/wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// wb_rr_arbiter
//   N-master to 1-slave Wishbone arbiter with fair round-robin selection.
//   The grant is registered; the slave-side bus and the master-side return
//   paths are steered by that registered one-hot grant. A grant is released
//   when the owner drops cyc, after each ack when REL_ON_ACK=1, or when a
//   strobe waits TIMEOUT cycles without ack (the owner then gets m_err_o).
//   Every release is followed by one dead cycle so that two owners never
//   see back-to-back cyc on the slave.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   m_cyc_i/stb_i/we_i  per-master Wishbone controls, NUM_M bits each
//   m_adr_i, m_dat_i  flattened master address / write data (k at [k*W +: W])
//   m_dat_o           read data, only the granted master's slice is non-zero
//   m_ack_o, m_err_o  ack / timeout error, only towards the granted master
//   s_cyc_o ... s_dat_o slave-side request
//   s_dat_i, s_ack_i  slave read data and ack
//   gnt_o             registered one-hot grant, zero when no owner
// ---------------------------------------------------------------------------
module wb_rr_arbiter #(
   parameter int NUM_M      = 3,
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int REL_ON_ACK = 0,
   parameter int TIMEOUT    = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_M-1:0]    m_cyc_i,
   input  logic [NUM_M-1:0]    m_stb_i,
   input  logic [NUM_M-1:0]    m_we_i,
   input  logic [NUM_M*AW-1:0] m_adr_i,
   input  logic [NUM_M*DW-1:0] m_dat_i,
   output logic [NUM_M*DW-1:0] m_dat_o,
   output logic [NUM_M-1:0]    m_ack_o,
   output logic [NUM_M-1:0]    m_err_o,
   output logic                s_cyc_o,
   output logic                s_stb_o,
   output logic                s_we_o,
   output logic [AW-1:0]       s_adr_o,
   output logic [DW-1:0]       s_dat_o,
   input  logic [DW-1:0]       s_dat_i,
   input  logic                s_ack_i,
   output logic [NUM_M-1:0]    gnt_o
);

   localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_REL  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [NUM_M-1:0] gnt_q, gnt_d;
   logic [IW-1:0]    ptr_q, ptr_d;

   logic [NUM_M-1:0] pick_s;
   logic             pick_vld_s;
   logic             sel_cyc_s;
   logic             sel_stb_s;
   logic             sel_we_s;
   logic [AW-1:0]    sel_adr_s;
   logic [DW-1:0]    sel_dat_s;
   logic [IW-1:0]    nxt_ptr_s;
   logic             to_hit_s;
   logic             rel_s;

   // Position 'off' steps after pointer p, wrapped into 0..NUM_M-1.
   function automatic int rr_idx(input logic [IW-1:0] p, input int off);
      int s;
      s = int'(p) + off;
      if (s >= NUM_M) begin
         s = s - NUM_M;
      end else begin
         s = s;
      end
      return s;
   endfunction

   // Round-robin search: first requester at ptr, ptr+1, ... (wrapping).
   always_comb begin
      pick_s     = '0;
      pick_vld_s = 1'b0;
      for (int i = 0; i < NUM_M; i++) begin
         for (int k = 0; k < NUM_M; k++) begin
            if (!pick_vld_s && m_cyc_i[k] && (rr_idx(ptr_q, i) == k)) begin
               pick_s[k]  = 1'b1;
               pick_vld_s = 1'b1;
            end else begin
               pick_vld_s = pick_vld_s;
            end
         end
      end
   end

   // Steer the owner's request onto internal select signals; gnt_q is zero
   // outside BUSY, so these are all zero there.
   always_comb begin
      sel_cyc_s = 1'b0;
      sel_stb_s = 1'b0;
      sel_we_s  = 1'b0;
      sel_adr_s = '0;
      sel_dat_s = '0;
      nxt_ptr_s = '0;
      for (int k = 0; k < NUM_M; k++) begin
         if (gnt_q[k]) begin
            sel_cyc_s = m_cyc_i[k];
            sel_stb_s = m_stb_i[k] & m_cyc_i[k];
            sel_we_s  = m_we_i[k];
            sel_adr_s = m_adr_i[k*AW +: AW];
            sel_dat_s = m_dat_i[k*DW +: DW];
            nxt_ptr_s = (k == NUM_M - 1) ? '0 : IW'(k + 1);
         end else begin
            sel_cyc_s = sel_cyc_s;
         end
      end
   end

   generate
      if (TIMEOUT > 0) begin : g_timeout
         localparam int CW = $clog2(TIMEOUT + 1);
         logic [CW-1:0] cnt_q, cnt_d;

         // Ack has priority: the timeout only fires on a cycle without ack.
         assign to_hit_s = sel_stb_s & ~s_ack_i & (cnt_q == CW'(TIMEOUT - 1));

         // Count strobe cycles left unanswered; any gap or ack restarts it.
         always_comb begin
            cnt_d = '0;
            if ((state_q != ST_BUSY) || rel_s) begin
               cnt_d = '0;
            end else if (sel_stb_s && !s_ack_i) begin
               cnt_d = cnt_q + CW'(1);
            end else begin
               cnt_d = '0;
            end
         end

         // Timeout counter register.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end
      end else begin : g_no_timeout
         assign to_hit_s = 1'b0;
      end
   endgenerate

   // Arbitration FSM and output steering.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      rel_s   = 1'b0;
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      s_we_o  = 1'b0;
      s_adr_o = '0;
      s_dat_o = '0;
      m_dat_o = '0;
      m_ack_o = '0;
      m_err_o = '0;
      case (state_q)
         ST_IDLE: begin
            if (pick_vld_s) begin
               gnt_d   = pick_s;
               state_d = ST_BUSY;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            // A timed-out request is withdrawn from the slave that cycle.
            s_cyc_o = sel_cyc_s & ~to_hit_s;
            s_stb_o = sel_stb_s & ~to_hit_s;
            s_we_o  = sel_we_s;
            s_adr_o = sel_adr_s;
            s_dat_o = sel_dat_s;
            for (int k = 0; k < NUM_M; k++) begin
               if (gnt_q[k]) begin
                  m_ack_o[k]           = s_ack_i & s_stb_o;
                  m_err_o[k]           = to_hit_s;
                  m_dat_o[k*DW +: DW]  = s_dat_i;
               end else begin
                  m_ack_o[k] = 1'b0;
               end
            end
            rel_s = ~sel_cyc_s
                  | ((REL_ON_ACK != 0) & s_ack_i & sel_stb_s)
                  | to_hit_s;
            if (rel_s) begin
               state_d = ST_REL;
               gnt_d   = '0;
               ptr_d   = nxt_ptr_s;
            end else begin
               state_d = ST_BUSY;
            end
         end
         ST_REL: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   // State, grant and round-robin pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
      end
   end

   assign gnt_o = gnt_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_rr_arbiter
//   Directed bench for wb_rr_arbiter. Two instances share the master-side
//   stimulus: u_dut_h holds the grant until cyc drops, u_dut_r releases after
//   every ack. Both use TIMEOUT=8. Inputs change on the falling edge and
//   outputs are compared 1 time unit later.
// ---------------------------------------------------------------------------
module tb_wb_rr_arbiter;

   logic        clk;
   logic        rst_n;
   logic [2:0]  m_cyc, m_stb, m_we;
   logic [95:0] m_adr, m_wdat;
   logic [31:0] s_rdat;
   logic        ack_h, ack_r;

   logic [95:0] m_dat_h, m_dat_r;
   logic [2:0]  m_ack_h, m_ack_r, m_err_h, m_err_r, gnt_h, gnt_r;
   logic        s_cyc_h, s_stb_h, s_we_h, s_cyc_r, s_stb_r, s_we_r;
   logic [31:0] s_adr_h, s_dat_h, s_adr_r, s_dat_r;
   logic [2:0]  exp;

   int n_checks;
   int n_errors;

   wb_rr_arbiter #(.NUM_M(3), .AW(32), .DW(32), .REL_ON_ACK(0), .TIMEOUT(8)) u_dut_h (
      .clk(clk), .rst_n(rst_n),
      .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
      .m_adr_i(m_adr), .m_dat_i(m_wdat),
      .m_dat_o(m_dat_h), .m_ack_o(m_ack_h), .m_err_o(m_err_h),
      .s_cyc_o(s_cyc_h), .s_stb_o(s_stb_h), .s_we_o(s_we_h),
      .s_adr_o(s_adr_h), .s_dat_o(s_dat_h),
      .s_dat_i(s_rdat), .s_ack_i(ack_h), .gnt_o(gnt_h)
   );

   wb_rr_arbiter #(.NUM_M(3), .AW(32), .DW(32), .REL_ON_ACK(1), .TIMEOUT(8)) u_dut_r (
      .clk(clk), .rst_n(rst_n),
      .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
      .m_adr_i(m_adr), .m_dat_i(m_wdat),
      .m_dat_o(m_dat_r), .m_ack_o(m_ack_r), .m_err_o(m_err_r),
      .s_cyc_o(s_cyc_r), .s_stb_o(s_stb_r), .s_we_o(s_we_r),
      .s_adr_o(s_adr_r), .s_dat_o(s_dat_r),
      .s_dat_i(s_rdat), .s_ack_i(ack_r), .gnt_o(gnt_r)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks = n_checks + 1;
      if (act !== exp_v) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp_v);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n  = 1'b0;
      m_cyc  = 3'b111;
      m_stb  = 3'b111;
      m_we   = 3'b000;
      m_adr  = {32'h0000_0222, 32'h0000_0010, 32'h0000_0AAA};
      m_wdat = {32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_1111};
      s_rdat = 32'h0;
      ack_h  = 1'b0;
      ack_r  = 1'b0;

      // Reset held with every master requesting, then first grant.
      step();
      #1;
      check_eq("rst_gnt", 32'(gnt_h), 32'h0);
      check_eq("rst_scyc", 32'(s_cyc_h), 32'h0);
      check_eq("rst_gnt_r", 32'(gnt_r), 32'h0);
      rst_n = 1'b1;
      step();
      #1;
      check_eq("first_gnt", 32'(gnt_h), 32'h1);
      check_eq("first_scyc", 32'(s_cyc_h), 32'h1);

      // Fairness on the release-on-ack instance: owner, ack, REL, IDLE.
      for (int r = 0; r < 6; r++) begin
         exp = 3'b001 << (r % 3);
         ack_r = 1'b0;
         #1;
         check_eq("fair_gnt_a", 32'(gnt_r), 32'(exp));
         check_eq("fair_scyc", 32'(s_cyc_r), 32'h1);
         step();
         ack_r = 1'b1;
         #1;
         check_eq("fair_gnt_b", 32'(gnt_r), 32'(exp));
         check_eq("fair_ack", 32'(m_ack_r), 32'(exp));
         step();
         ack_r = 1'b0;
         #1;
         check_eq("fair_rel_gnt", 32'(gnt_r), 32'h0);
         check_eq("fair_rel_scyc", 32'(s_cyc_r), 32'h0);
         step();
         #1;
         check_eq("fair_idle_gnt", 32'(gnt_r), 32'h0);
         step();
      end

      // Routing: master1 writes, masters 0 and 2 idle.
      m_cyc = 3'b010;
      m_stb = 3'b010;
      m_we  = 3'b010;
      do_reset();
      step();
      ack_h  = 1'b1;
      s_rdat = 32'h1234_5678;
      #1;
      check_eq("rt_gnt", 32'(gnt_h), 32'h2);
      check_eq("rt_adr", s_adr_h, 32'h0000_0010);
      check_eq("rt_dat", s_dat_h, 32'hDEAD_BEEF);
      check_eq("rt_we", 32'(s_we_h), 32'h1);
      check_eq("rt_ack", 32'(m_ack_h), 32'h2);
      check_eq("rt_rd0", m_dat_h[31:0], 32'h0);
      check_eq("rt_rd1", m_dat_h[63:32], 32'h1234_5678);
      check_eq("rt_rd2", m_dat_h[95:64], 32'h0);
      step();
      m_cyc = 3'b000;
      m_stb = 3'b000;
      m_we  = 3'b000;
      ack_h = 1'b0;
      #1;
      check_eq("rt_drop_scyc", 32'(s_cyc_h), 32'h0);
      check_eq("rt_drop_ack", 32'(m_ack_h), 32'h0);

      // Burst hold: master0 keeps cyc over 4 acks while master2 waits.
      m_cyc = 3'b101;
      m_stb = 3'b101;
      do_reset();
      step();
      for (int b = 0; b < 4; b++) begin
         ack_h = 1'b1;
         #1;
         check_eq("bh_gnt", 32'(gnt_h), 32'h1);
         check_eq("bh_ack", 32'(m_ack_h), 32'h1);
         step();
      end
      m_cyc = 3'b100;
      m_stb = 3'b100;
      ack_h = 1'b0;
      #1;
      check_eq("bh_drop_gnt", 32'(gnt_h), 32'h1);
      check_eq("bh_drop_scyc", 32'(s_cyc_h), 32'h0);
      step();
      #1;
      check_eq("bh_rel_gnt", 32'(gnt_h), 32'h0);
      step();
      #1;
      check_eq("bh_idle_gnt", 32'(gnt_h), 32'h0);
      step();
      #1;
      check_eq("bh_gnt2", 32'(gnt_h), 32'h4);
      check_eq("bh_adr2", s_adr_h, 32'h0000_0222);

      // Timeout: master0 never acked, error on the 8th strobe cycle.
      m_cyc = 3'b011;
      m_stb = 3'b011;
      do_reset();
      step();
      for (int i = 1; i < 8; i++) begin
         #1;
         check_eq("to_noerr", 32'(m_err_h), 32'h0);
         step();
      end
      #1;
      check_eq("to_err", 32'(m_err_h), 32'h1);
      check_eq("to_scyc", 32'(s_cyc_h), 32'h0);
      check_eq("to_sstb", 32'(s_stb_h), 32'h0);
      step();
      #1;
      check_eq("to_rel_gnt", 32'(gnt_h), 32'h0);
      step();
      step();
      #1;
      check_eq("to_next_gnt", 32'(gnt_h), 32'h2);
      // Same again for master1, but the slave acks on the 8th cycle.
      for (int i = 1; i < 8; i++) begin
         step();
      end
      ack_h = 1'b1;
      #1;
      check_eq("to_ack_win", 32'(m_ack_h), 32'h2);
      check_eq("to_ack_noerr", 32'(m_err_h), 32'h0);
      check_eq("to_ack_scyc", 32'(s_cyc_h), 32'h1);
      step();
      ack_h = 1'b0;
      #1;
      check_eq("to_after_gnt", 32'(gnt_h), 32'h2);
      check_eq("to_after_err", 32'(m_err_h), 32'h0);

      // Asynchronous reset between clock edges while busy.
      m_cyc = 3'b001;
      m_stb = 3'b001;
      do_reset();
      step();
      ack_h = 1'b1;
      #1;
      check_eq("ar_busy_scyc", 32'(s_cyc_h), 32'h1);
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("ar_scyc", 32'(s_cyc_h), 32'h0);
      check_eq("ar_gnt", 32'(gnt_h), 32'h0);
      check_eq("ar_ack", 32'(m_ack_h), 32'h0);
      ack_h = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
